// File: rtl/ss_display_scan.sv
// ss_display_scan: multiplexed seven-segment scanner with frame snapshot,
// programmable slot length, dead time, leading-zero blanking and pin polarity.
`default_nettype none

module ss_display_scan #(
   parameter int N_DIGITS   = 8,
   parameter int SCAN_DIV   = 131072,
   parameter int BLANK_CYC  = 1024,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    lz_blank,
   input  logic [4*N_DIGITS-1:0]   data_bcd,
   input  logic [N_DIGITS-1:0]     dp_in,
   output logic [N_DIGITS-1:0]     an,
   output logic [6:0]              seg,
   output logic                    dp_out,
   output logic                    frame_start
);

   localparam int c_CW = $clog2(SCAN_DIV);
   localparam int c_IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(SCAN_DIV - 1);
   localparam logic [c_CW-1:0] c_BLANK   = c_CW'(BLANK_CYC);
   localparam logic [c_IW-1:0] c_IDX_MAX = c_IW'(N_DIGITS - 1);
   localparam logic            c_OFF     = (ACTIVE_LOW != 0);

   logic [c_CW-1:0]         r_cnt;
   logic [c_IW-1:0]         r_idx;
   logic [4*N_DIGITS-1:0]   r_shadow;
   logic [N_DIGITS-1:0]     r_shadow_dp;

   logic                    w_tick;
   logic                    w_frame;
   logic                    w_lit;
   logic [N_DIGITS-1:0]     w_dig_zero;
   logic [N_DIGITS-1:0]     w_zero_from;
   logic [3:0]              w_digit;
   logic                    w_dp_sel;
   logic                    w_zsel;
   logic                    w_blanked;
   logic                    w_show;
   logic [N_DIGITS-1:0]     w_an_log;
   logic [6:0]              w_seg_log;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'h0:    f_decode = 7'h3F;
         4'h1:    f_decode = 7'h06;
         4'h2:    f_decode = 7'h5B;
         4'h3:    f_decode = 7'h4F;
         4'h4:    f_decode = 7'h66;
         4'h5:    f_decode = 7'h6D;
         4'h6:    f_decode = 7'h7D;
         4'h7:    f_decode = 7'h07;
         4'h8:    f_decode = 7'h7F;
         4'h9:    f_decode = 7'h6F;
         4'hA:    f_decode = 7'h40;
         default: f_decode = 7'h00;
      endcase
   endfunction

   assign w_tick  = (r_cnt == c_CNT_MAX);
   assign w_frame = w_tick && (r_idx == c_IDX_MAX);

   // A zero dead time means the digit is lit for the whole slot.
   generate
      if (BLANK_CYC > 0) begin : g_dead_time
         assign w_lit = (r_cnt >= c_BLANK);
      end else begin : g_no_dead_time
         assign w_lit = 1'b1;
      end
   endgenerate

   always_comb begin
      w_dig_zero  = '0;
      w_zero_from = '0;
      w_digit     = 4'h0;
      w_dp_sel    = 1'b0;
      w_zsel      = 1'b0;
      w_an_log    = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         w_dig_zero[i] = (r_shadow[4*i +: 4] == 4'h0);
      end
      // Digit i is a leading zero when it and every digit to its left are zero.
      for (int i = 0; i < N_DIGITS; i++) begin
         w_zero_from[i] = 1'b1;
         for (int j = i; j < N_DIGITS; j++) begin
            if (!w_dig_zero[j]) w_zero_from[i] = 1'b0;
         end
      end
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == c_IW'(i)) begin
            w_digit  = r_shadow[4*i +: 4];
            w_dp_sel = r_shadow_dp[i];
            w_zsel   = w_zero_from[i];
         end
      end
      w_blanked = lz_blank && (r_idx != '0) && w_zsel;
      w_show    = en && w_lit && !w_blanked;
      for (int i = 0; i < N_DIGITS; i++) begin
         w_an_log[i] = w_show && (r_idx == c_IW'(i));
      end
      w_seg_log = w_show ? f_decode(w_digit) : 7'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         frame_start <= 1'b0;
         an          <= {N_DIGITS{c_OFF}};
         seg         <= {7{c_OFF}};
         dp_out      <= c_OFF;
      end else begin
         if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IW'(1);
         end else begin
            r_cnt <= r_cnt + c_CW'(1);
         end
         if (w_frame) begin
            r_shadow    <= data_bcd;
            r_shadow_dp <= dp_in;
         end
         frame_start <= w_frame;
         an          <= w_an_log ^ {N_DIGITS{c_OFF}};
         seg         <= w_seg_log ^ {7{c_OFF}};
         dp_out      <= (w_show && w_dp_sel) ^ c_OFF;
      end
   end

endmodule

`default_nettype wire

// File: doc/ss_display_scan.md
Name: ss_display_scan

Overview:
- Parametrised multiplexed seven-segment display driver; successor to the fixed 8-digit scanner.
- Time-multiplexes N_DIGITS BCD nibbles onto one shared segment bus with a one-hot digit enable.
- Adds:
  - frame-coherent data snapshot
  - programmable scan rate
  - anti-ghosting dead time
  - leading-zero blanking
  - per-digit decimal point
  - output polarity select
- Sits between display-data producers (counters, BCD converters) and the board's digit/segment pins.

Parameters:
- N_DIGITS, 8, number of digits (legal range 1..16).
- SCAN_DIV, 131072, clk cycles per digit slot (minimum 2).
- BLANK_CYC, 1024, cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- ACTIVE_LOW, 0.
  - 1: an, seg and dp_out are inverted at the pins.
  - 0: all outputs are active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  display enable; 0 forces all digits off, scanning continues
- lz_blank  in  1  leading-zero blanking enable
- data_bcd  in  4*N_DIGITS  digit i = data_bcd[4i+3:4i]; digit 0 is rightmost
- dp_in  in  N_DIGITS  decimal point per digit
- an  out  N_DIGITS  one-hot digit enable
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point of the active digit
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, idx=0, shadow data and dp = 0, frame_start=0.
  - an, seg, dp_out are driven to the logical off state (all 0 before polarity; all 1 at the pins if ACTIVE_LOW).
- Prescaler and digit index:
  - Prescaler cnt counts 0..SCAN_DIV-1; tick = (cnt==SCAN_DIV-1).
  - On tick, cnt<=0 and idx<=idx+1, wrapping from N_DIGITS-1 to 0.
- Snapshot:
  - On the tick where idx==N_DIGITS-1, the shadow registers load data_bcd and dp_in, and frame_start pulses high for the next cycle.
  - Input changes mid-frame are never visible until the next frame.
  - After reset, the first frame displays the shadow reset value.
- Output timing: all outputs are registered, one clk after the (cnt, idx, shadow) state they reflect.
  - Logical an[idx]=1 only when en=1, cnt>=BLANK_CYC, and the digit is not blanked; all other an bits are 0.
  - When the digit is blanked or en=0, seg=0 and dp_out=0.
- Decode (logical, before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 4'hA = 40 (dash).
  - 4'hB..4'hF = 00 (blank; an is still asserted).
- Leading-zero blanking: with lz_blank=1, digit i (i>0) is blanked when shadow digits i..N_DIGITS-1 all equal 0.
  - Digit 0 is never blanked.
  - dp of a blanked digit is suppressed.
- dp_out = shadow_dp[idx] when the digit is shown.
- N_DIGITS=1: idx is constant 0, and every tick is a frame tick.
- en toggles take effect on the outputs 1 cycle later; cnt, idx and the snapshot are unaffected by en.
- Reset asserted mid-slot forces the off state immediately (asynchronously); scanning restarts from idx 0, cnt 0.

Test Plan:
- Bench configuration: N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, ACTIVE_LOW=0.
- 1. Scan order and timing: release reset, data_bcd=16'h4321, en=1.
  - After the first frame, each slot shows an=0000 for 1 cycle, then 3 cycles of one-hot an.
  - Sequence: an=0001/seg=06, 0010/5B, 0100/4F, 1000/66.
  - frame_start pulses once every 16 cycles.
- 2. Snapshot coherency: change data_bcd from 16'h1111 to 16'h2222 while idx=1.
  - Digits 2 and 3 still show seg=06.
  - seg=5B appears only after the next frame_start.
- 3. Leading-zero blanking: data_bcd=16'h0050, lz_blank=1.
  - Digits 3 and 2 stay dark (an=0, seg=0).
  - Digit 1 shows seg=6D; digit 0 shows seg=3F.
  - With lz_blank=0, digits 3 and 2 show seg=3F.
- 4. Dash, blank and dp: data_bcd=16'hA0FB, dp_in=4'b0100.
  - Digit 3 shows seg=40.
  - Digit 2 shows seg=3F with dp_out=1.
  - Digits 1 and 0 have an asserted and seg=00.
- 5. Polarity: rerun scenario 1 with ACTIVE_LOW=1; an, seg and dp_out must be the bitwise inverse of scenario 1 (e.g. an=1110, seg=7'h79 for digit 0).
- 6. Enable and reset: en=0 for one frame gives an=0 and seg=0 throughout.
  - Then assert rst_n=0 mid-slot: outputs go to off with no clk edge.
  - After release, scanning resumes at idx 0, with the first frame_start 16 cycles later.
